// File: rtl/mesh_router.sv
// Five-port XY mesh router: per-input FIFOs, dimension-ordered routing,
// off-mesh drop, and per-output round-robin arbitration into one-entry output registers.
module mesh_router #(
  parameter int X_COORD    = 0,
  parameter int Y_COORD    = 0,
  parameter int MESH_X     = 2,
  parameter int MESH_Y     = 2,
  parameter int COORD_W    = 2,
  parameter int DATA_W     = 7,
  parameter int FIFO_DEPTH = 4,
  localparam int FLIT_W    = 2*COORD_W + DATA_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [5*FLIT_W-1:0] in_data,
  input  logic [4:0]          in_valid,
  output logic [4:0]          in_ready,
  output logic [5*FLIT_W-1:0] out_data,
  output logic [4:0]          out_valid,
  input  logic [4:0]          out_ready,
  output logic                drop_pulse
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] P_LOCAL = 3'd0;
  localparam logic [2:0] P_NORTH = 3'd1;
  localparam logic [2:0] P_EAST  = 3'd2;
  localparam logic [2:0] P_SOUTH = 3'd3;
  localparam logic [2:0] P_WEST  = 3'd4;

  // Input FIFO state
  logic [FLIT_W-1:0] r_mem      [5][FIFO_DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr   [5];
  logic [PTR_W-1:0]  r_wr_ptr   [5];
  logic [CNT_W-1:0]  r_count    [5];
  logic [4:0]        r_full;

  // Output registers and arbitration state
  logic [FLIT_W-1:0] r_out_data [5];
  logic [4:0]        r_out_vld;
  logic [2:0]        r_last     [5];
  logic              r_drop;

  logic [FLIT_W-1:0] w_head     [5];
  logic [4:0]        w_head_vld;
  logic [4:0]        w_is_drop;
  logic [4:0]        w_drop_pop;
  logic [4:0]        w_push;
  logic [4:0]        w_pop;
  logic [CNT_W-1:0]  w_cnt_nxt  [5];
  logic [2:0]        w_route    [5];
  logic [4:0]        w_req      [5];
  logic [4:0]        w_gnt      [5];
  logic [2:0]        w_gnt_idx  [5];
  logic [4:0]        w_gnt_any;
  logic [4:0]        w_free;

  function automatic logic [2:0] xy_route(input logic [COORD_W-1:0] dx,
                                          input logic [COORD_W-1:0] dy);
    logic [2:0] dir;
    if (int'(dx) > X_COORD)      dir = P_EAST;
    else if (int'(dx) < X_COORD) dir = P_WEST;
    else if (int'(dy) > Y_COORD) dir = P_NORTH;
    else if (int'(dy) < Y_COORD) dir = P_SOUTH;
    else                         dir = P_LOCAL;
    return dir;
  endfunction

  function automatic logic off_mesh(input logic [COORD_W-1:0] dx,
                                    input logic [COORD_W-1:0] dy);
    return (int'(dx) >= MESH_X) || (int'(dy) >= MESH_Y);
  endfunction

  function automatic logic [2:0] rr_next(input logic [2:0] last, input int k);
    int n;
    n = (int'(last) + k) % 5;
    return n[2:0];
  endfunction

  always_comb begin
    for (int p = 0; p < 5; p++) begin
      w_head[p]     = r_mem[p][r_rd_ptr[p]];
      w_head_vld[p] = (r_count[p] != '0);
      w_is_drop[p]  = off_mesh(w_head[p][FLIT_W-1 -: COORD_W], w_head[p][DATA_W +: COORD_W]);
      w_route[p]    = xy_route(w_head[p][FLIT_W-1 -: COORD_W], w_head[p][DATA_W +: COORD_W]);
      w_push[p]     = in_valid[p] && !r_full[p];
    end
  end

  // Only one drop per cycle so every discarded flit gets its own pulse.
  always_comb begin
    w_drop_pop = '0;
    for (int p = 0; p < 5; p++)
      if (w_head_vld[p] && w_is_drop[p] && (w_drop_pop == '0))
        w_drop_pop[p] = 1'b1;
  end

  always_comb begin
    logic [2:0] cand;
    cand = '0;
    for (int o = 0; o < 5; o++) begin
      w_free[o]    = !r_out_vld[o] || out_ready[o];
      w_gnt[o]     = '0;
      w_gnt_idx[o] = r_last[o];
      w_gnt_any[o] = 1'b0;
      for (int p = 0; p < 5; p++)
        w_req[o][p] = w_head_vld[p] && !w_is_drop[p] && (w_route[p] == 3'(o));
      if (w_free[o]) begin
        for (int k = 1; k <= 5; k++) begin
          cand = rr_next(r_last[o], k);
          if (!w_gnt_any[o] && w_req[o][cand]) begin
            w_gnt_any[o] = 1'b1;
            w_gnt_idx[o] = cand;
            w_gnt[o]     = 5'b00001 << cand;
          end
        end
      end
    end
  end

  always_comb begin
    w_pop = w_drop_pop;
    for (int o = 0; o < 5; o++)
      w_pop = w_pop | w_gnt[o];
    for (int p = 0; p < 5; p++)
      w_cnt_nxt[p] = r_count[p] + CNT_W'(w_push[p]) - CNT_W'(w_pop[p]);
  end

  // Control state: pointers, occupancy, output registers, arbitration history
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int p = 0; p < 5; p++) begin
        r_rd_ptr[p]   <= '0;
        r_wr_ptr[p]   <= '0;
        r_count[p]    <= '0;
        r_last[p]     <= 3'd4;
        r_out_data[p] <= '0;
      end
      r_full    <= '0;
      r_out_vld <= '0;
      r_drop    <= 1'b0;
    end else begin
      for (int p = 0; p < 5; p++) begin
        if (w_push[p]) r_wr_ptr[p] <= r_wr_ptr[p] + PTR_W'(1);
        if (w_pop[p])  r_rd_ptr[p] <= r_rd_ptr[p] + PTR_W'(1);
        r_count[p] <= w_cnt_nxt[p];
        r_full[p]  <= (w_cnt_nxt[p] == CNT_W'(FIFO_DEPTH));
      end
      for (int o = 0; o < 5; o++) begin
        if (w_gnt_any[o]) begin
          r_out_vld[o]  <= 1'b1;
          r_out_data[o] <= w_head[w_gnt_idx[o]];
          r_last[o]     <= w_gnt_idx[o];
        end else if (out_ready[o]) begin
          r_out_vld[o]  <= 1'b0;
        end
      end
      r_drop <= |w_drop_pop;
    end
  end

  // FIFO storage needs no reset; pointers define what is valid.
  always_ff @(posedge clock) begin
    for (int p = 0; p < 5; p++)
      if (w_push[p]) r_mem[p][r_wr_ptr[p]] <= in_data[p*FLIT_W +: FLIT_W];
  end

  always_comb begin
    out_data = '0;
    for (int o = 0; o < 5; o++)
      out_data[o*FLIT_W +: FLIT_W] = r_out_data[o];
  end

  assign in_ready   = ~r_full;
  assign out_valid  = r_out_vld;
  assign drop_pulse = r_drop;

endmodule
